// File: rtl/gb_bus_pkg.sv
// Shared bus definitions for the DMA/CPU memory arbitration slice.
// Contents:
//   bus_tag_t        - tag that travels alongside a CPU read until its data returns
//   ADDR_IDLE        - address value meaning "no access" on any bus
//   OPEN_BUS         - value returned for reads that reach no device
//   IO_BASE_DEFAULT  - lowest address decoded onto the I/O bus
//   OAM_BASE         - start of object attribute memory (DMA destination)
package gb_bus_pkg;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_CPU_EXT,
        TAG_CPU_IO,
        TAG_CPU_BLK
    } bus_tag_t;

    localparam logic [15:0] ADDR_IDLE       = 16'hFFFF;
    localparam logic [7:0]  OPEN_BUS        = 8'hFF;
    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;
    localparam logic [15:0] OAM_BASE        = 16'hFE00;

endpackage

// File: rtl/mem_if.sv
// Byte-wide memory port bundle.
// Signals:
//   addr_select  - 16-bit address, ADDR_IDLE when no access
//   write_enable - 1 = write cycle, 0 = read cycle
//   write_value  - write data
//   read_out     - read data returned to the requester
// Modports: master drives the request and receives read_out,
//           slave receives the request and drives read_out.
interface mem_if;
    logic [15:0] addr_select;
    logic        write_enable;
    logic [7:0]  write_value;
    logic [7:0]  read_out;

    modport master (output addr_select, output write_enable, output write_value,
                    input read_out);
    modport slave  (input addr_select, input write_enable, input write_value,
                    output read_out);
endinterface

// File: rtl/dma_bus_arbiter_tag_pipe.sv
// Fixed-depth shift register of bus_tag_t values. A tag written at tag_in
// appears at tag_out DEPTH clock edges later, aligned with the read data
// of the downstream bus it describes.
// Ports:
//   clk, rst - clock, synchronous active-high reset (all stages -> TAG_NONE)
//   tag_in   - tag for the access presented this cycle
//   tag_out  - tag leaving the pipe this cycle
module bus_tag_pipe
    import gb_bus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  bus_tag_t tag_in,
    output bus_tag_t tag_out
);

    bus_tag_t stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= TAG_NONE;
            end
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/dma_bus_arbiter.sv
// Arbitrates the CPU and OAM DMA masters onto the external/video bus and
// the I/O bus, and enforces the DMA lockout on the CPU.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   cpu_req       - CPU memory requests (slave side)
//   dma_req       - DMA engine requests; addr_select == ADDR_IDLE when idle
//   ext_bus       - external/video bus (0x0000 - IO_BASE-1), master side
//   io_bus        - I/O + HRAM + IE bus (IO_BASE - 0xFFFF), master side
//   dma_busy      - CPU lockout from external bus in effect
//   blocked_count - saturating count of cycles a CPU external access was blocked
// Bus requests are combinational from the masters' requests; read data for
// the CPU is captured on the edge that closes the cycle in which the bus
// returns it (READ_LATENCY cycles after the address was presented).
module dma_bus_arbiter
    import gb_bus_pkg::*;
#(
    parameter int          READ_LATENCY = 2,
    parameter int          DMA_TAIL     = 2,
    parameter logic [15:0] IO_BASE      = IO_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    mem_if.slave       cpu_req,
    mem_if.slave       dma_req,
    mem_if.master      ext_bus,
    mem_if.master      io_bus,
    output logic       dma_busy,
    output logic [7:0] blocked_count
);

    localparam int TAIL_W = (DMA_TAIL < 2) ? 1 : $clog2(DMA_TAIL + 1);

    logic [TAIL_W-1:0] tail_q;
    logic              dma_act;
    logic              cpu_io;
    logic              cpu_idle;
    logic              blocked;
    bus_tag_t          tag_in;
    bus_tag_t          tag_out;

    // Reset gates dma_act so both buses fall idle while rst is high,
    // not one edge later.
    assign dma_act  = !rst && (dma_req.addr_select != ADDR_IDLE);
    assign dma_busy = dma_act || (tail_q != '0);
    assign cpu_io   = cpu_req.addr_select >= IO_BASE;
    assign cpu_idle = cpu_req.addr_select == ADDR_IDLE;
    assign blocked  = dma_busy && !cpu_io && !cpu_idle;

    // External bus: DMA has absolute priority; the CPU only gets it once
    // the lockout tail has drained.
    always_comb begin
        ext_bus.addr_select  = ADDR_IDLE;
        ext_bus.write_enable = 1'b0;
        ext_bus.write_value  = 8'h00;
        if (dma_act) begin
            ext_bus.addr_select  = dma_req.addr_select;
            ext_bus.write_enable = dma_req.write_enable;
            ext_bus.write_value  = dma_req.write_value;
        end else if (!rst && !dma_busy && !cpu_io) begin
            ext_bus.addr_select  = cpu_req.addr_select;
            ext_bus.write_enable = cpu_req.write_enable;
            ext_bus.write_value  = cpu_req.write_value;
        end
    end

    // I/O bus belongs to the CPU alone, DMA or not.
    always_comb begin
        io_bus.addr_select  = ADDR_IDLE;
        io_bus.write_enable = 1'b0;
        io_bus.write_value  = 8'h00;
        if (!rst && cpu_io) begin
            io_bus.addr_select  = cpu_req.addr_select;
            io_bus.write_enable = cpu_req.write_enable;
            io_bus.write_value  = cpu_req.write_value;
        end
    end

    // Only CPU reads need a tag; writes and idle cycles push TAG_NONE so
    // read_out keeps its last value.
    always_comb begin
        tag_in = TAG_NONE;
        if (!rst && !cpu_idle && !cpu_req.write_enable) begin
            if (cpu_io) begin
                tag_in = TAG_CPU_IO;
            end else if (dma_busy) begin
                tag_in = TAG_CPU_BLK;
            end else begin
                tag_in = TAG_CPU_EXT;
            end
        end
    end

    bus_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign dma_req.read_out = rst ? OPEN_BUS : ext_bus.read_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            tail_q           <= '0;
            blocked_count    <= 8'h00;
            cpu_req.read_out <= OPEN_BUS;
        end else begin
            if (dma_act) begin
                tail_q <= TAIL_W'(DMA_TAIL);
            end else if (tail_q != '0) begin
                tail_q <= tail_q - 1'b1;
            end

            if (blocked && (blocked_count != 8'hFF)) begin
                blocked_count <= blocked_count + 8'h01;
            end

            case (tag_out)
                TAG_CPU_EXT: cpu_req.read_out <= ext_bus.read_out;
                TAG_CPU_IO:  cpu_req.read_out <= io_bus.read_out;
                TAG_CPU_BLK: cpu_req.read_out <= OPEN_BUS;
                default:     cpu_req.read_out <= cpu_req.read_out;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter. Downstream buses are modelled as
// byte memories with a two-stage read pipeline (data valid two cycles
// after the address is presented). Inputs are driven 1 time unit after
// the rising edge; outputs are checked before the next rising edge.
module tb_dma_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dma_busy;
    logic [7:0] blocked_count;

    int tests_run = 0;
    int failures  = 0;
    int ext_wr_cnt = 0;
    logic [7:0] exp_q [$];

    mem_if cpu_bus ();
    mem_if dma_bus ();
    mem_if ext_bus ();
    mem_if io_bus ();

    dma_bus_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_bus),
        .dma_req       (dma_bus),
        .ext_bus       (ext_bus),
        .io_bus        (io_bus),
        .dma_busy      (dma_busy),
        .blocked_count (blocked_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- downstream memory models ----------------
    logic [7:0] ext_mem [65536];
    logic [7:0] io_mem  [256];
    logic [7:0] ext_p0 = 8'hFF, ext_p1 = 8'hFF;
    logic [7:0] io_p0  = 8'hFF, io_p1  = 8'hFF;

    always @(posedge clk) begin
        if (ext_bus.write_enable) ext_mem[ext_bus.addr_select] <= ext_bus.write_value;
        if (io_bus.write_enable)  io_mem[io_bus.addr_select[7:0]] <= io_bus.write_value;
        ext_p0 <= ext_mem[ext_bus.addr_select];
        ext_p1 <= ext_p0;
        io_p0  <= io_mem[io_bus.addr_select[7:0]];
        io_p1  <= io_p0;
        if (!rst && ext_bus.write_enable) ext_wr_cnt <= ext_wr_cnt + 1;
    end

    assign ext_bus.read_out = ext_p1;
    assign io_bus.read_out  = io_p1;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic [15:0] a, input logic we, input logic [7:0] wv);
        cpu_bus.addr_select  = a;
        cpu_bus.write_enable = we;
        cpu_bus.write_value  = wv;
    endtask

    task automatic dma_set(input logic [15:0] a, input logic we, input logic [7:0] wv);
        dma_bus.addr_select  = a;
        dma_bus.write_enable = we;
        dma_bus.write_value  = wv;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_read(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        check(tag, {8'h00, cpu_bus.read_out}, {8'h00, e});
    endtask

    // ---------------- stimulus ----------------
    int wr_before;

    initial begin
        cpu_set(16'hFFFF, 1'b0, 8'h00);
        dma_set(16'hFFFF, 1'b0, 8'h00);
        repeat (3) tick();

        // Reset state (rst still high)
        check("rst_ext_addr", ext_bus.addr_select, 16'hFFFF);
        check("rst_ext_we", {15'h0, ext_bus.write_enable}, 16'h0);
        check("rst_ext_wv", {8'h0, ext_bus.write_value}, 16'h0);
        check("rst_io_addr", io_bus.addr_select, 16'hFFFF);
        check("rst_cpu_rd", {8'h0, cpu_bus.read_out}, 16'h00FF);
        check("rst_dma_rd", {8'h0, dma_bus.read_out}, 16'h00FF);
        check("rst_busy", {15'h0, dma_busy}, 16'h0);
        check("rst_count", {8'h0, blocked_count}, 16'h0);
        rst = 1'b0;
        tick();

        // 1: no DMA, CPU writes then reads back C000
        cpu_set(16'hC000, 1'b1, 8'h5A);
        #1;
        check("t1_ext_addr", ext_bus.addr_select, 16'hC000);
        check("t1_ext_we", {15'h0, ext_bus.write_enable}, 16'h1);
        check("t1_ext_wv", {8'h0, ext_bus.write_value}, 16'h005A);
        check("t1_io_idle", io_bus.addr_select, 16'hFFFF);
        tick();
        cpu_set(16'hC100, 1'b1, 8'hA7);
        tick();
        cpu_set(16'hD000, 1'b1, 8'hE4);
        tick();
        cpu_set(16'hC000, 1'b0, 8'h00);
        exp_q.push_back(8'h5A);
        #1;
        check("t1_rd_io_idle", io_bus.addr_select, 16'hFFFF);
        tick();
        cpu_set(16'hFFFF, 1'b0, 8'h00);
        tick();
        check("t1_rd_not_yet", {8'h0, cpu_bus.read_out}, 16'h00FF);
        tick();
        check_read("t1_rd_data");

        // 2: DMA starts at C100 while CPU reads C000
        dma_set(16'hC100, 1'b0, 8'h00);
        cpu_set(16'hC000, 1'b0, 8'h00);
        #1;
        check("t2_ext_addr", ext_bus.addr_select, 16'hC100);
        check("t2_ext_we", {15'h0, ext_bus.write_enable}, 16'h0);
        check("t2_busy", {15'h0, dma_busy}, 16'h1);
        tick();
        check("t2_count", {8'h0, blocked_count}, 16'h0001);
        dma_set(16'hFFFF, 1'b0, 8'h00);
        cpu_set(16'hFFFF, 1'b0, 8'h00);
        tick();
        check("t2_cpu_hold", {8'h0, cpu_bus.read_out}, 16'h005A);
        #1;
        check("t2_dma_rd", {8'h0, dma_bus.read_out}, 16'h00A7);
        tick();
        check("t2_cpu_open_bus", {8'h0, cpu_bus.read_out}, 16'h00FF);

        // 3: during DMA, CPU writes and reads HRAM FF80
        dma_set(16'h8000, 1'b0, 8'h00);
        cpu_set(16'hFF80, 1'b1, 8'h11);
        #1;
        check("t3_io_addr", io_bus.addr_select, 16'hFF80);
        check("t3_io_we", {15'h0, io_bus.write_enable}, 16'h1);
        check("t3_io_wv", {8'h0, io_bus.write_value}, 16'h0011);
        check("t3_ext_dma", ext_bus.addr_select, 16'h8000);
        check("t3_ext_we", {15'h0, ext_bus.write_enable}, 16'h0);
        tick();
        cpu_set(16'hFF80, 1'b0, 8'h00);
        exp_q.push_back(8'h11);
        #1;
        check("t3_io_rd_we", {15'h0, io_bus.write_enable}, 16'h0);
        tick();
        cpu_set(16'hFFFF, 1'b0, 8'h00);
        tick();
        tick();
        check_read("t3_rd_data");
        check("t3_count", {8'h0, blocked_count}, 16'h0001);
        dma_set(16'hFFFF, 1'b0, 8'h00);
        repeat (3) tick();
        check("t3_busy_drained", {15'h0, dma_busy}, 16'h0);

        // 4: DMA writes FE9F, releases while CPU holds a read of D000
        dma_set(16'hFE9F, 1'b1, 8'h3C);
        cpu_set(16'hD000, 1'b0, 8'h00);
        #1;
        check("t4_ext_addr", ext_bus.addr_select, 16'hFE9F);
        check("t4_ext_we", {15'h0, ext_bus.write_enable}, 16'h1);
        check("t4_ext_wv", {8'h0, ext_bus.write_value}, 16'h003C);
        tick();
        check("t4_count_a", {8'h0, blocked_count}, 16'h0002);
        dma_set(16'hFFFF, 1'b0, 8'h00);
        #1;
        check("t4_tail1_ext", ext_bus.addr_select, 16'hFFFF);
        check("t4_tail1_busy", {15'h0, dma_busy}, 16'h1);
        tick();
        check("t4_tail2_ext", ext_bus.addr_select, 16'hFFFF);
        check("t4_tail2_busy", {15'h0, dma_busy}, 16'h1);
        tick();
        check("t4_count_b", {8'h0, blocked_count}, 16'h0004);
        check("t4_grant_busy", {15'h0, dma_busy}, 16'h0);
        check("t4_grant_addr", ext_bus.addr_select, 16'hD000);
        exp_q.push_back(8'hE4);
        tick();
        cpu_set(16'hFFFF, 1'b0, 8'h00);
        check("t4_count_c", {8'h0, blocked_count}, 16'h0004);
        tick();
        tick();
        check_read("t4_rd_data");

        // 5: blocked CPU write held for 300 cycles
        dma_set(16'h8000, 1'b0, 8'h00);
        cpu_set(16'hC000, 1'b1, 8'h99);
        wr_before = ext_wr_cnt;
        repeat (300) begin
            tick();
        end
        check("t5_count_sat", {8'h0, blocked_count}, 16'h00FF);
        check("t5_no_ext_wr", 16'(ext_wr_cnt - wr_before), 16'h0);
        check("t5_ext_dma", ext_bus.addr_select, 16'h8000);

        // 6: reset asserted mid-DMA
        check("t6_busy_pre", {15'h0, dma_busy}, 16'h1);
        rst = 1'b1;
        #1;
        check("t6_ext_idle_now", ext_bus.addr_select, 16'hFFFF);
        tick();
        check("t6_busy", {15'h0, dma_busy}, 16'h0);
        check("t6_ext_addr", ext_bus.addr_select, 16'hFFFF);
        check("t6_ext_we", {15'h0, ext_bus.write_enable}, 16'h0);
        check("t6_io_addr", io_bus.addr_select, 16'hFFFF);
        check("t6_cpu_rd", {8'h0, cpu_bus.read_out}, 16'h00FF);
        check("t6_count", {8'h0, blocked_count}, 16'h0);
        dma_set(16'hFFFF, 1'b0, 8'h00);
        cpu_set(16'hFFFF, 1'b0, 8'h00);
        rst = 1'b0;
        tick();
        check("t6_tail_cleared", {15'h0, dma_busy}, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Responder side of the OAM DMA engine's memory master port.
- Sits between the CPU memory master, the DMA master and two downstream buses:
  - the external/video bus (0x0000–0xFEFF: ROM, VRAM, WRAM, OAM);
  - the I/O bus (0xFF00–0xFFFF: I/O registers, HRAM, IE).
- Grants the external bus to DMA whenever DMA is active and routes DMA read data back.
- Enforces the DMA lockout: during DMA the CPU may reach only the I/O bus. External-bus CPU reads return 0xFF and external-bus CPU writes are dropped.

Parameters:
- READ_LATENCY, 2, cycles from address presented to read_out valid on either downstream bus.
- DMA_TAIL, 2, cycles the CPU lockout persists after DMA releases the bus.
- IO_BASE, 16'hFF00, lowest address routed to the I/O bus.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- cpu_req  mem_if.slave  —  CPU requests (addr_select, write_enable, write_value in; read_out out)
- dma_req  mem_if.slave  —  DMA engine requests; addr_select==16'hFFFF means idle
- ext_bus  mem_if.master  —  external/video memory bus
- io_bus  mem_if.master  —  I/O + HRAM bus
- dma_busy  output  1  CPU lockout in effect
- blocked_count  output  8  saturating count of dropped or blocked CPU external accesses

Behaviour:
- Reset values:
  - ext_bus/io_bus: addr_select=16'hFFFF, write_enable=0, write_value=0.
  - cpu_req.read_out=8'hFF; dma_req.read_out=8'hFF.
  - dma_busy=0, blocked_count=0, tail counter=0, all tag stages=TAG_NONE.
- dma_act = (dma_req.addr_select != 16'hFFFF). This is combinational, so no cycle is lost; the DMA engine presents an address and expects it on the bus the same cycle.
- Tail counter:
  - loads DMA_TAIL on every cycle dma_act=1;
  - otherwise decrements to 0.
- dma_busy = dma_act || tail counter != 0.
- CPU region: cpu_io = cpu_req.addr_select >= IO_BASE.
- ext_bus routing:
  - if dma_act, carries the dma_req fields verbatim;
  - else if !dma_busy and !cpu_io, carries the cpu_req fields;
  - else idle (addr_select=16'hFFFF, write_enable=0).
- ext_bus/io_bus outputs are combinational from their inputs; only tags, tail counter, counters and read_out are registered.
- io_bus routing: carries the cpu_req fields when cpu_io, otherwise idle. DMA never drives io_bus.
- Blocked access: dma_busy && !cpu_io && cpu_req.addr_select != 16'hFFFF.
  - Writes are dropped and nothing reaches ext_bus.
  - Reads return 8'hFF.
  - blocked_count increments once per cycle the condition holds and saturates at 8'hFF.
- Read return (tag pipeline):
  - Each cycle a tag is pushed into a READ_LATENCY-deep shift register: TAG_NONE, TAG_CPU_EXT, TAG_CPU_IO, TAG_CPU_BLK.
  - cpu_req.read_out is registered from the tag leaving the pipe:
    - TAG_CPU_EXT → ext_bus.read_out;
    - TAG_CPU_IO → io_bus.read_out;
    - TAG_CPU_BLK → 8'hFF;
    - TAG_NONE → hold the previous value.
- dma_req.read_out = ext_bus.read_out, combinational passthrough. The DMA engine samples it after its own two-cycle read wait.
- Simultaneous CPU ext access and DMA start in the same cycle: DMA wins. The CPU access is treated as blocked and counted.
- DMA release mid-CPU request: the CPU stays blocked for DMA_TAIL more cycles, then is granted on the next cycle with no extra delay.
- CPU write to 0xFF46 during DMA goes to io_bus normally; restart is the DMA engine's responsibility.
- Reset mid-DMA: all state returns to reset values on the next edge and buses go idle immediately.

Decomposition:
- Shared package gb_bus_pkg:
  - typedef bus_tag_t {TAG_NONE, TAG_CPU_EXT, TAG_CPU_IO, TAG_CPU_BLK};
  - constants ADDR_IDLE=16'hFFFF, OPEN_BUS=8'hFF, IO_BASE_DEFAULT=16'hFF00, OAM_BASE=16'hFE00.
- One sub-module: bus_tag_pipe (parameterised-depth bus_tag_t shift register with reset to TAG_NONE).

Test Plan:
- No DMA, CPU write C000=5A then read C000 → ext_bus sees addr C000 we=1 wv 5A; cpu read_out=5A two cycles after the read address; io_bus stays idle.
- DMA addr C100 while CPU reads C000 → ext_bus.addr=C100; dma read_out tracks ext data; CPU gets FF after 2 cycles; blocked_count=1.
- During DMA, CPU write FF80=11 then read FF80 → io_bus we=1 wv 11; read returns 11; ext_bus untouched; blocked_count unchanged.
- DMA drives FE9F write, then releases (FFFF) while CPU holds a read of D000 → blocked for 2 cycles (count +2); granted on the 3rd cycle; data arrives 2 cycles later.
- Hold a blocked CPU write for 300 cycles → blocked_count saturates at FF and no ext write ever occurs.
- Assert rst mid-DMA with dma_busy=1 → next cycle: dma_busy=0, buses idle (FFFF/we 0), cpu read_out=FF, count=0.
